countdown_controller: RTL and testbench



---
 rtl/countdown_controller.sv | 186 ++++++++++++++++++
 tb/tb_countdown_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_controller.sv
// countdown_controller: HHMMSS BCD countdown with 1 Hz prescaler and alarm.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the preset after each alarm.
module countdown_controller #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] load_value,
  input  logic        load,
  input  logic        start_stop,
  input  logic        clear,
  output logic [23:0] countdown_display,
  output logic        running,
  output logic        expired,
  output logic        alarm_out
);

  localparam int unsigned PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    ALARM_N = 8'(ALARM_SECS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_e;

  // Digit order from bit 0: ss_u, ss_t, mm_u, mm_t, hh_u, hh_t.
  function automatic logic [3:0] dig_max(input int idx);
    return (idx == 1 || idx == 3) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [23:0] sat_bcd(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  d;
    logic [3:0]  lim;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      d   = v[i*4 +: 4];
      lim = dig_max(i);
      r[i*4 +: 4] = (d > lim) ? lim : d;
    end
    return r;
  endfunction

  function automatic logic [23:0] dec_bcd(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  d;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = v[i*4 +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[i*4 +: 4] = dig_max(i);
        end else begin
          r[i*4 +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [23:0]   preset_q, preset_d;
  logic [23:0]   cnt_q, cnt_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [7:0]    asec_q, asec_d;
  logic          run_q, run_d;
  logic          exp_q, exp_d;
  logic          alm_q, alm_d;

  logic          tick;
  logic          cnt_zero;
  logic          load_ok;
  logic [PW-1:0] ps_inc;
  logic [7:0]    asec_inc;
  logic [23:0]   cnt_dec;
  logic [23:0]   load_sat;

  assign tick     = (ps_q == PS_LAST);
  assign ps_inc   = tick ? '0 : PW'(ps_q + 1'b1);
  assign asec_inc = asec_q + 8'd1;
  assign cnt_zero = (cnt_q == '0);
  assign cnt_dec  = dec_bcd(cnt_q);
  assign load_sat = sat_bcd(load_value);
  assign load_ok  = load && (state_q != RUN);

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    cnt_d    = cnt_q;
    ps_d     = ps_q;
    asec_d   = asec_q;
    if (clear) begin
      cnt_d   = preset_q;
      ps_d    = '0;
      asec_d  = '0;
      state_d = IDLE;
    end else if (load_ok) begin
      preset_d = load_sat;
      cnt_d    = load_sat;
      ps_d     = '0;
      asec_d   = '0;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_stop && !cnt_zero) state_d = RUN;
        end
        RUN: begin
          ps_d = ps_inc;
          if (tick && !cnt_zero) cnt_d = cnt_dec;
          // Reaching zero beats a pause request on the same tick.
          if (tick && !cnt_zero && cnt_dec == '0) begin
            asec_d  = '0;
            state_d = EXPIRED;
          end else if (start_stop) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (start_stop) state_d = RUN;
        end
        EXPIRED: begin
          if (start_stop) begin
            cnt_d   = preset_q;
            ps_d    = '0;
            asec_d  = '0;
            state_d = IDLE;
          end else begin
            ps_d = ps_inc;
            if (tick && asec_q != ALARM_N) asec_d = asec_inc;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (tick && asec_inc == ALARM_N &&
                preset_q != '0) begin
              cnt_d   = preset_q;
              ps_d    = '0;
              asec_d  = '0;
              state_d = RUN;
            end
`else
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
    run_d = (state_d == RUN);
    exp_d = (state_d == EXPIRED);
    alm_d = exp_d && (asec_d != ALARM_N);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      preset_q <= '0;
      cnt_q    <= '0;
      ps_q     <= '0;
      asec_q   <= '0;
      run_q    <= 1'b0;
      exp_q    <= 1'b0;
      alm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      cnt_q    <= cnt_d;
      ps_q     <= ps_d;
      asec_q   <= asec_d;
      run_q    <= run_d;
      exp_q    <= exp_d;
      alm_q    <= alm_d;
    end
  end

  assign countdown_display = cnt_q;
  assign running           = run_q;
  assign expired           = exp_q;
  assign alarm_out         = alm_q;

endmodule

// File: tb/tb_countdown_controller.sv
// tb_countdown_controller: directed vector table plus corner sequences.
// Runs with TICK_DIV=4, ALARM_SECS=2.
module tb_countdown_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] load_value = '0;
  logic        load = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] countdown_display;
  logic        running;
  logic        expired;
  logic        alarm_out;

  int checks = 0;
  int errors = 0;

  countdown_controller #(
    .TICK_DIV  (4),
    .ALARM_SECS(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .load_value       (load_value),
    .load             (load),
    .start_stop       (start_stop),
    .clear            (clear),
    .countdown_display(countdown_display),
    .running          (running),
    .expired          (expired),
    .alarm_out        (alarm_out)
  );

  always #5 clk = ~clk;

  wire [26:0] obs = {countdown_display, running, expired, alarm_out};

  typedef struct {
    bit          rst;
    bit          ld;
    logic [23:0] val;
    bit          ss;
    bit          clr;
    logic [23:0] disp;
    bit          r;
    bit          e;
    bit          a;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input bit rst, input bit ld,
                              input logic [23:0] val, input bit ss,
                              input bit clr, input logic [23:0] disp,
                              input bit r, input bit e, input bit a);
    vec_t v;
    v.rst = rst; v.ld = ld; v.val = val; v.ss = ss; v.clr = clr;
    v.disp = disp; v.r = r; v.e = e; v.a = a;
    vq.push_back(v);
  endfunction

  function automatic void idl(input int n, input logic [23:0] disp,
                              input bit r, input bit e, input bit a);
    for (int k = 0; k < n; k++) add(0, 0, '0, 0, 0, disp, r, e, a);
  endfunction

  task automatic cyc(input bit rst, input bit ld, input logic [23:0] val,
                     input bit ss, input bit clr);
    reset = rst; load = ld; load_value = val;
    start_stop = ss; clear = clr;
    @(posedge clk);
    #1;
    reset = 1'b0; load = 1'b0; start_stop = 1'b0; clear = 1'b0;
  endtask

  task automatic chk(input string name, input logic [26:0] act,
                     input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got disp=%h r/e/a=%b required disp=%h r/e/a=%b",
               name, act[26:3], act[2:0], exp[26:3], exp[2:0]);
    end
  endtask

  initial begin
    int n;
    // reset, start at zero, saturation, basic countdown from 5
    add(1, 0, '0, 0, 0, 24'h000000, 0, 0, 0);
    add(0, 0, '0, 1, 0, 24'h000000, 0, 0, 0);
    add(0, 1, 24'h9A7F6C, 0, 0, 24'h995959, 0, 0, 0);
    add(0, 1, 24'h000005, 0, 0, 24'h000005, 0, 0, 0);
    add(0, 0, '0, 1, 0, 24'h000005, 1, 0, 0);
    idl(3, 24'h5, 1, 0, 0); idl(1, 24'h4, 1, 0, 0);
    idl(3, 24'h4, 1, 0, 0); idl(1, 24'h3, 1, 0, 0);
    idl(3, 24'h3, 1, 0, 0); idl(1, 24'h2, 1, 0, 0);
    idl(3, 24'h2, 1, 0, 0); idl(1, 24'h1, 1, 0, 0);
    idl(3, 24'h1, 1, 0, 0); idl(1, 24'h0, 0, 1, 1);
    idl(7, 24'h0, 0, 1, 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    idl(2, 24'h5, 1, 0, 0);
`else
    idl(2, 24'h0, 0, 1, 0);
`endif
    add(0, 0, '0, 1, 0, 24'h000005, 0, 0, 0);
    // borrow chains
    add(0, 1, 24'h010000, 0, 0, 24'h010000, 0, 0, 0);
    add(0, 0, '0, 1, 0, 24'h010000, 1, 0, 0);
    idl(3, 24'h010000, 1, 0, 0); idl(1, 24'h005959, 1, 0, 0);
    add(0, 0, '0, 0, 1, 24'h010000, 0, 0, 0);
    add(0, 1, 24'h100000, 0, 0, 24'h100000, 0, 0, 0);
    add(0, 0, '0, 1, 0, 24'h100000, 1, 0, 0);
    idl(3, 24'h100000, 1, 0, 0); idl(1, 24'h095959, 1, 0, 0);
    // clear+load+start_stop together in RUN, then load ignored in RUN
    add(0, 1, 24'h000123, 1, 1, 24'h100000, 0, 0, 0);
    add(0, 0, '0, 1, 0, 24'h100000, 1, 0, 0);
    idl(1, 24'h100000, 1, 0, 0);
    add(0, 1, 24'h000007, 0, 0, 24'h100000, 1, 0, 0);
    idl(1, 24'h100000, 1, 0, 0); idl(1, 24'h095959, 1, 0, 0);
    add(0, 0, '0, 0, 1, 24'h100000, 0, 0, 0);
    // pause two cycles into a second, resume
    add(0, 1, 24'h000010, 0, 0, 24'h000010, 0, 0, 0);
    add(0, 0, '0, 1, 0, 24'h000010, 1, 0, 0);
    idl(1, 24'h000010, 1, 0, 0);
    add(0, 0, '0, 1, 0, 24'h000010, 0, 0, 0);
    idl(100, 24'h000010, 0, 0, 0);
    add(0, 0, '0, 1, 0, 24'h000010, 1, 0, 0);
    idl(1, 24'h000010, 1, 0, 0); idl(1, 24'h000009, 1, 0, 0);
    idl(3, 24'h000009, 1, 0, 0);
    add(0, 0, '0, 1, 0, 24'h000008, 0, 0, 0);
    idl(2, 24'h000008, 0, 0, 0);
    // start_stop on the final tick: expiry wins; then load in EXPIRED
    add(0, 1, 24'h000001, 0, 0, 24'h000001, 0, 0, 0);
    add(0, 0, '0, 1, 0, 24'h000001, 1, 0, 0);
    idl(3, 24'h000001, 1, 0, 0);
    add(0, 0, '0, 1, 0, 24'h000000, 0, 1, 1);
    add(0, 1, 24'h000003, 0, 0, 24'h000003, 0, 0, 0);
    // reset in the middle of the alarm
    add(0, 0, '0, 1, 0, 24'h000003, 1, 0, 0);
    idl(3, 24'h3, 1, 0, 0); idl(1, 24'h2, 1, 0, 0);
    idl(3, 24'h2, 1, 0, 0); idl(1, 24'h1, 1, 0, 0);
    idl(3, 24'h1, 1, 0, 0); idl(2, 24'h0, 0, 1, 1);
    add(1, 0, '0, 0, 0, 24'h000000, 0, 0, 0);
    add(0, 0, '0, 1, 0, 24'h000000, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].rst, vq[i].ld, vq[i].val, vq[i].ss, vq[i].clr);
      chk($sformatf("vec%0d", i), obs,
          {vq[i].disp, vq[i].r, vq[i].e, vq[i].a});
    end

    // reset while running
    cyc(0, 1, 24'h000030, 0, 0);
    cyc(0, 0, '0, 1, 0);
    repeat (6) cyc(0, 0, '0, 0, 0);
    chk("run_before_reset", obs, {24'h000029, 3'b100});
    cyc(1, 0, '0, 0, 0);
    chk("reset_mid_run", obs, {24'h000000, 3'b000});

    // expiry from 2 with a bounded wait, then alarm end / auto reload
    cyc(0, 1, 24'h000002, 0, 0);
    cyc(0, 0, '0, 1, 0);
    n = 0;
    while (!expired && n < 40) begin
      cyc(0, 0, '0, 0, 0);
      n++;
    end
    chk("expire_latency", {24'(n), 3'b000}, {24'd8, 3'b000});
    chk("expire_state", obs, {24'h000000, 3'b011});
    repeat (8) cyc(0, 0, '0, 0, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    chk("auto_reload", obs, {24'h000002, 3'b100});
    repeat (8) cyc(0, 0, '0, 0, 0);
    chk("auto_second_expiry", obs, {24'h000000, 3'b011});
`else
    chk("alarm_done_hold", obs, {24'h000000, 3'b010});
    repeat (8) cyc(0, 0, '0, 0, 0);
    chk("expired_holds", obs, {24'h000000, 3'b010});
`endif
    cyc(0, 0, '0, 1, 0);
    chk("ack_to_idle", obs, {24'h000002, 3'b000});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
